adc_dc_filter: RTL and testbench

Sample-conditioning stage between `spi2adc` and the downstream echo/delay processing and `spi2dac`/`pwm` outputs. On each ADC `data_valid` strobe it does the following:
- Maintains a 256-sample boxcar running mean of the incoming 10-bit offset-binary samples.
- Subtracts that mean to remove DC offset and re-centres the result on mid-scale (512), with saturation.
- Reports a per-window peak deviation for the HEX display.

It runs on the 50 MHz system clock and processes one sample per ADC conversion (10 kHz nominal).

---
 rtl/adc_dc_filter.sv | 110 +++++++++++
 tb/tb_adc_dc_filter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_dc_filter.sv
// DC-offset removal for the ADC sample stream: 256-sample boxcar mean, mean subtraction
// re-centred on mid-scale with saturation, and a per-window peak deviation for display.
module adc_dc_filter #(
  parameter int DW    = 10,
  parameter int LOG2N = 8
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          data_valid,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic [DW-1:0] mean,
  output logic [DW-1:0] peak_level,
  output logic          overrun
);

  localparam int            N   = 1 << LOG2N;
  localparam int            SW  = DW + LOG2N;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX = {DW{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, UPDATE, OUT} state_t;

  state_t             state, state_next;
  logic [DW-1:0]      x;
  logic [DW-1:0]      old;
  logic [DW-1:0]      mem [N];
  logic [LOG2N-1:0]   ptr;
  logic               fill;
  logic [SW-1:0]      sum;
  logic [DW-1:0]      window_max;
  logic signed [DW+1:0] y;
  logic [DW-1:0]      y_sat;
  logic [DW-1:0]      dev;
  logic [DW-1:0]      dev_max;

  assign mean = sum[SW-1:LOG2N];

  // NOTE: the sample RAM has no reset; unwritten words are masked by fill, and a
  // reset term here would stop it mapping onto block RAM.
  always_ff @(posedge sysclk) begin
    if (state == UPDATE) mem[ptr] <= x;
    old <= mem[ptr];
  end

  // NOTE: every signal driven here gets a value before any branch so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (data_valid) state_next = READ;
      READ:    state_next = UPDATE;
      UPDATE:  state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In OUT, mean already reflects the sum updated by this sample.
  always_comb begin
    y     = signed'({2'b00, x}) - signed'({2'b00, mean}) + signed'({2'b00, MID});
    y_sat = y[DW-1:0];
    if (y < 0)                            y_sat = '0;
    else if (y > signed'({2'b00, MAX}))   y_sat = MAX;
    dev     = (y_sat >= MID) ? (y_sat - MID) : (MID - y_sat);
    dev_max = (dev > window_max) ? dev : window_max;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      ptr        <= '0;
      fill       <= 1'b0;
      sum        <= '0;
      window_max <= '0;
      data_out   <= MID;
      out_valid  <= 1'b0;
      peak_level <= '0;
      overrun    <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      if (data_valid && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: if (data_valid) x <= data_in;
        UPDATE: begin
          sum <= sum + SW'(x) - (fill ? SW'(old) : SW'(0));
          ptr <= ptr + 1'b1;
          if (&ptr) fill <= 1'b1;
        end
        OUT: begin
          data_out  <= y_sat;
          out_valid <= 1'b1;
          // ptr back at zero means this sample closed a window.
          if (ptr == '0) begin
            peak_level <= dev_max;
            window_max <= '0;
          end else begin
            window_max <= dev_max;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dc_filter.sv
// Self-checking bench for adc_dc_filter: behavioural model feeds a scoreboard queue,
// a table of hand-computed vectors, and directed reset/overrun/wrap sequences.
module tb_adc_dc_filter;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       data_valid;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       out_valid;
  logic [9:0] mean;
  logic [9:0] peak_level;
  logic       overrun;

  always #10 sysclk = ~sysclk;

  adc_dc_filter #(.DW(10), .LOG2N(8)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .mean(mean),
    .peak_level(peak_level), .overrun(overrun)
  );

  typedef struct { int dout; int mn; int pk; } exp_t;
  typedef struct { int din; int dout; int mn; int pk; } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  // Reference model state
  int m_mem [256];
  int m_sum, m_ptr, m_fill, m_wmax, m_peak;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_ptr = 0; m_fill = 0; m_wmax = 0; m_peak = 0;
    sb.delete();
  endtask

  task automatic model_step(input int v, output exp_t e);
    int old, mn, y, dev;
    bit wrapped;
    old = m_mem[m_ptr];
    m_sum = m_sum + v - (m_fill != 0 ? old : 0);
    m_mem[m_ptr] = v;
    wrapped = (m_ptr == 255);
    m_ptr = (m_ptr + 1) % 256;
    if (wrapped) m_fill = 1;
    mn = m_sum / 256;
    y = v - mn + 512;
    if (y < 0) y = 0;
    if (y > 1023) y = 1023;
    dev = (y >= 512) ? y - 512 : 512 - y;
    if (wrapped) begin
      m_peak = (dev > m_wmax) ? dev : m_wmax;
      m_wmax = 0;
    end else if (dev > m_wmax) begin
      m_wmax = dev;
    end
    e.dout = y; e.mn = mn; e.pk = m_peak;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every out_valid must match the oldest expected result.
  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_data_out", int'(data_out), e.dout);
        check("sb_mean", int'(mean), e.mn);
        check("sb_peak", int'(peak_level), e.pk);
      end
    end
  end

  // One accepted sample with latency checks; leaves the DUT idle after 5 cycles.
  task automatic send(input int v);
    exp_t e;
    @(negedge sysclk);
    data_valid = 1'b1; data_in = 10'(v);
    model_step(v, e);
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    check("mean_before_strobe", int'(mean), e.mn);
    check("out_valid_early", int'(out_valid), 0);
    @(negedge sysclk);
    check("out_valid_latency4", int'(out_valid), 1);
    @(negedge sysclk);
    check("out_valid_one_cycle", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0; data_valid = 1'b1; data_in = 10'd123;
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk); data_valid = 1'b1; data_in = 10'd900;
    @(negedge sysclk); data_valid = 1'b0; rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vt [5];

  initial begin
    int p0;
    exp_t e;
    vt[0] = '{din: 700,  dout: 1023, mn: 2, pk: 0};
    vt[1] = '{din: 0,    dout: 510,  mn: 2, pk: 0};
    vt[2] = '{din: 100,  dout: 609,  mn: 3, pk: 0};
    vt[3] = '{din: 1023, dout: 1023, mn: 7, pk: 0};
    vt[4] = '{din: 5,    dout: 510,  mn: 7, pk: 0};

    rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
    do_reset();
    repeat (3) @(negedge sysclk);
    check("rst_data_out", int'(data_out), 512);
    check("rst_mean", int'(mean), 0);
    check("rst_peak", int'(peak_level), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_no_pulse", pulses, 0);

    // Table vectors from reset: first sample saturates high, fill underestimates mean.
    for (int i = 0; i < 5; i++) begin
      send(vt[i].din);
      check("vec_data_out", int'(data_out), vt[i].dout);
      check("vec_mean", int'(mean), vt[i].mn);
      check("vec_peak", int'(peak_level), vt[i].pk);
    end

    // Reset while in READ aborts the sample.
    p0 = pulses;
    @(negedge sysclk); data_valid = 1'b1; data_in = 10'd50;
    @(negedge sysclk); data_valid = 1'b0; rst_n = 1'b0;
    @(negedge sysclk); rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge sysclk);
    check("abort_no_pulse", pulses - p0, 0);
    check("abort_data_out", int'(data_out), 512);
    check("abort_mean", int'(mean), 0);

    // Strobes exactly 4 cycles apart are both accepted.
    p0 = pulses;
    @(negedge sysclk); data_valid = 1'b1; data_in = 10'd200; model_step(200, e);
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    @(negedge sysclk);
    check("spacing4_first_out", int'(out_valid), 1);
    data_valid = 1'b1; data_in = 10'd800; model_step(800, e);
    @(negedge sysclk); data_valid = 1'b0;
    repeat (6) @(negedge sysclk);
    check("spacing4_pulses", pulses - p0, 2);
    check("spacing4_no_overrun", int'(overrun), 0);

    // Back-to-back strobes: second is dropped and flags overrun.
    p0 = pulses;
    @(negedge sysclk); data_valid = 1'b1; data_in = 10'd600; model_step(600, e);
    @(negedge sysclk); data_in = 10'd100;
    @(negedge sysclk); data_valid = 1'b0;
    repeat (6) @(negedge sysclk);
    check("overrun_pulses", pulses - p0, 1);
    check("overrun_set", int'(overrun), 1);
    send(300);
    check("overrun_sticky", int'(overrun), 1);

    // Steady state at 700, then step to 1000 and a single 0.
    do_reset();
    for (int i = 0; i < 520; i++) begin
      send(700);
      if (i >= 255) begin
        check("steady_mean", int'(mean), 700);
        check("steady_data_out", int'(data_out), 512);
      end
    end
    check("steady_peak_zero", int'(peak_level), 0);
    for (int i = 0; i < 256; i++) send(1000);
    check("step_mean_full", int'(mean), 1000);
    send(0);
    check("sat_low_data_out", int'(data_out), 0);
    check("step_mean", int'(mean), 996);

    // Window peak and pointer wrap.
    do_reset();
    for (int i = 0; i < 256; i++) send(512);
    check("wrap_ptr_0", int'(dut.ptr), m_ptr);
    check("fill_peak", int'(peak_level), 510);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 612 : 412);
      check("wrap_ptr", int'(dut.ptr), m_ptr);
      check("alt_peak", int'(peak_level), 100);
    end

    repeat (4) @(negedge sysclk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
